sparse_pe_cartesian: RTL and testbench
======================================

Name: sparse_pe_cartesian

Overview:
- Next-generation sparse-CNN processing element: latches a group of F non-zero weights with coordinates, then streams compressed activation vectors of I non-zeros.
- Each accepted activation vector yields the full F×I Cartesian product: products, output coordinates and a validity mask.
- Sits between the weight/activation fetch front-end and the scatter/accumulator crossbar.
- Generalises the earlier fixed 4-weight PE: parametrised widths, real handshake, per-lane masks, output channel tagging, full-precision products.

Parameters:
- F, 4, weights per group (product rows).
- I, 4, activations per vector (product columns).
- WL, 16, signed data word width.
- IDX_W, 5, coordinate width (row/col) for weights and activations.
- CH_W, 6, channel tag width.
- CNT_W, 16, width of the activation-vector count.

Ports:
- clk  in  1  clock, rising edge.
- irst_n  in  1  reset, synchronous, active-low.
- cfg_num_act  in  CNT_W  activation vectors per group; sampled on first weight beat.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  PE accepts weight beat.
- w_data  in  WL  signed weight.
- w_row / w_col  in  IDX_W each  weight kernel coordinates.
- w_ch  in  CH_W  output channel of group; sampled on first weight beat.
- w_last  in  1  final weight beat of group.
- a_valid  in  1  activation vector valid.
- a_ready  out  1  PE accepts vector.
- a_data  in  I*WL  signed activations, lane k at [k*WL +: WL].
- a_row / a_col  in  I*IDX_W each  activation coordinates per lane.
- a_mask  in  I  lane-valid bits.
- out_valid  out  1  product block valid.
- out_ready  in  1  downstream accepts.
- out_data  out  F*I*2*WL  signed products, entry (f,i) at index f*I+i.
- out_row / out_col  out  F*I*(IDX_W+1) each  output coordinates.
- out_mask  out  F*I  entry valid.
- out_ch  out  CH_W  channel tag.
- group_done  out  1  one-cycle pulse when last vector of group leaves output register.

Behaviour:
- Reset (irst_n=0 at clk edge): state IDLE; all outputs 0 except w_ready=1; weight bank, masks, counters cleared. Reset mid-group abandons the group; no group_done.
- States: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE: w_ready=1, a_ready=0. On w_valid, beat stored at slot 0 and cfg_num_act/w_ch latched; go LOAD_W, or straight to STREAM if w_last.
- LOAD_W: w_ready=1. Each beat goes to the next slot 1..F-1.
  - Slot F-1 or w_last ends the load; go STREAM.
  - Unfilled slots have weight-mask 0.
  - Beats past slot F-1 cannot occur, since w_ready=0 once the bank is full.
- STREAM: w_ready=0; a_ready = !out_valid | out_ready (one-entry skid-free pipeline).
  - On a_valid&a_ready, the output register loads next cycle (latency 1):
    - out_data(f,i) = w(f)*a(i), full 2*WL signed.
    - out_row = a_row(i)+w_row(f), out_col = a_col(i)+w_col(f), unsigned, IDX_W+1 bits, no wrap.
    - out_mask = wmask(f)&a_mask(i); out_ch = latched channel.
  - Zero-value operands are not skipped here; masks carry sparsity.
  - The accepted-vector counter increments. When it reaches cfg_num_act, go DRAIN.
  - cfg_num_act=0: zero vectors are accepted; go directly to DRAIN.
- out_valid holds with stable data until out_ready. Accept and output in the same cycle overwrite the register seamlessly.
- DRAIN: a_ready=0. When the output register is empty, or its last entry handshakes, pulse group_done and go IDLE.
  - For cfg_num_act=0, group_done pulses on the cycle after entering DRAIN.
- Weights for the next group are never accepted before group_done. The weight bank is cleared on entering IDLE.

Test Plan:
- F=I=4, load weights {1,-2,3,4} at (0,0),(0,1),(1,0),(1,1), w_ch=5, cfg_num_act=2; two vectors a={10,20,30,40}, rows=cols=2, mask=1111, out_ready=1 -> out_data(1,2)=-60, out_row(1,2)=2, out_col(1,2)=3, out_mask all 1, out_ch=5, latency 1, group_done on cycle after second output.
- Short group: w_last on 2nd beat -> out_mask rows 2,3 zero; a_mask=0101 -> out_mask=0000_0000_0101_0101.
- Backpressure: out_ready=0 for 3 cycles with a_valid=1 -> a_ready=0, out_data stable; release -> no vector lost or duplicated (count 3 vectors).
- Extremes: w=-32768, a=-32768 -> product +1073741824; coords 31+31 -> 62 with no wrap.
- cfg_num_act=0 -> no out_valid, group_done pulse, w_ready=1 in IDLE after.
- irst_n low during STREAM -> next cycle all outputs 0, w_ready=1, no group_done; fresh group then completes normally.

Source files
------------

// File: rtl/sparse_pe_cartesian.sv
// Sparse-CNN PE: latches up to F weights, then emits the F x I Cartesian product per activation vector.
// Latency 1 from vector accept to out_valid; a_ready drops while a held output block is not accepted.
module sparse_pe_cartesian #(
  parameter int F     = 4,
  parameter int I     = 4,
  parameter int WL    = 16,
  parameter int IDX_W = 5,
  parameter int CH_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       irst_n,
  input  logic [CNT_W-1:0]           cfg_num_act,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [WL-1:0]              w_data,
  input  logic [IDX_W-1:0]           w_row,
  input  logic [IDX_W-1:0]           w_col,
  input  logic [CH_W-1:0]            w_ch,
  input  logic                       w_last,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [I*WL-1:0]            a_data,
  input  logic [I*IDX_W-1:0]         a_row,
  input  logic [I*IDX_W-1:0]         a_col,
  input  logic [I-1:0]               a_mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [F*I*2*WL-1:0]        out_data,
  output logic [F*I*(IDX_W+1)-1:0]   out_row,
  output logic [F*I*(IDX_W+1)-1:0]   out_col,
  output logic [F*I-1:0]             out_mask,
  output logic [CH_W-1:0]            out_ch,
  output logic                       group_done
);

  localparam int SLOT_W = (F > 1) ? $clog2(F) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(F - 1);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;
  state_t state_q, state_d;

  logic [WL-1:0]     w_q    [F];
  logic [IDX_W-1:0]  wrow_q [F];
  logic [IDX_W-1:0]  wcol_q [F];
  logic [F-1:0]      wmask_q;
  logic [SLOT_W-1:0] slot_q, w_slot;
  logic [CNT_W-1:0]  num_q, cnt_q;
  logic [CH_W-1:0]   ch_q;
  logic              w_fire, a_fire, drain_done;

  logic [F*I*2*WL-1:0]      p_data;
  logic [F*I*(IDX_W+1)-1:0] p_row, p_col;
  logic [F*I-1:0]           p_mask;

  assign w_fire = w_valid & w_ready;
  assign a_fire = a_valid & a_ready;
  assign w_slot = (state_q == IDLE) ? '0 : slot_q;

  always_comb begin
    state_d    = state_q;
    w_ready    = 1'b0;
    a_ready    = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        w_ready = 1'b1;
        if (w_valid) state_d = (w_last || F == 1) ? STREAM : LOAD_W;
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid && (w_last || slot_q == LAST_SLOT)) state_d = STREAM;
      end
      STREAM: begin
        // A zero-length group never opens the activation port.
        if (cnt_q == num_q) begin
          state_d = DRAIN;
        end else begin
          a_ready = !out_valid || out_ready;
          if (a_valid && a_ready && (cnt_q + CNT_W'(1) == num_q)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid || out_ready) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Full cross product; masked entries are still computed, the mask carries sparsity.
  always_comb begin
    p_data = '0;
    p_row  = '0;
    p_col  = '0;
    p_mask = '0;
    for (int f = 0; f < F; f++) begin
      for (int i = 0; i < I; i++) begin
        p_data[(f*I+i)*2*WL +: 2*WL] =
          {{WL{w_q[f][WL-1]}}, w_q[f]} * {{WL{a_data[i*WL+WL-1]}}, a_data[i*WL +: WL]};
        p_row[(f*I+i)*(IDX_W+1) +: IDX_W+1] = {1'b0, a_row[i*IDX_W +: IDX_W]} + {1'b0, wrow_q[f]};
        p_col[(f*I+i)*(IDX_W+1) +: IDX_W+1] = {1'b0, a_col[i*IDX_W +: IDX_W]} + {1'b0, wcol_q[f]};
        p_mask[f*I+i] = wmask_q[f] & a_mask[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!irst_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      ch_q       <= '0;
      wmask_q    <= '0;
      for (int f = 0; f < F; f++) begin
        w_q[f]    <= '0;
        wrow_q[f] <= '0;
        wcol_q[f] <= '0;
      end
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_mask   <= '0;
      out_ch     <= '0;
      group_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      group_done <= drain_done;

      if (w_fire) begin
        w_q[w_slot]     <= w_data;
        wrow_q[w_slot]  <= w_row;
        wcol_q[w_slot]  <= w_col;
        wmask_q[w_slot] <= 1'b1;
        slot_q          <= w_slot + SLOT_W'(1);
        if (state_q == IDLE) begin
          num_q <= cfg_num_act;
          ch_q  <= w_ch;
        end
      end

      if (drain_done) begin
        slot_q  <= '0;
        cnt_q   <= '0;
        wmask_q <= '0;
        for (int f = 0; f < F; f++) begin
          w_q[f]    <= '0;
          wrow_q[f] <= '0;
          wcol_q[f] <= '0;
        end
      end

      if (a_fire) begin
        cnt_q     <= cnt_q + CNT_W'(1);
        out_valid <= 1'b1;
        out_data  <= p_data;
        out_row   <= p_row;
        out_col   <= p_col;
        out_mask  <= p_mask;
        out_ch    <= ch_q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sparse_pe_cartesian.sv
// Directed bench for sparse_pe_cartesian: table of single-vector groups plus multi-cycle sequences.
module tb_sparse_pe_cartesian;
  localparam int F = 4, I = 4, WL = 16, IDX_W = 5, CH_W = 6, CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     irst_n;
  logic [CNT_W-1:0]         cfg_num_act;
  logic                     w_valid, w_ready, w_last;
  logic [WL-1:0]            w_data;
  logic [IDX_W-1:0]         w_row, w_col;
  logic [CH_W-1:0]          w_ch;
  logic                     a_valid, a_ready;
  logic [3:0][15:0]         a_data;
  logic [3:0][4:0]          a_row, a_col;
  logic [I-1:0]             a_mask;
  logic                     out_valid, out_ready, group_done;
  logic [F*I*2*WL-1:0]      out_data;
  logic [F*I*(IDX_W+1)-1:0] out_row, out_col;
  logic [F*I-1:0]           out_mask;
  logic [CH_W-1:0]          out_ch;

  sparse_pe_cartesian #(.F(F), .I(I), .WL(WL), .IDX_W(IDX_W), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .irst_n(irst_n), .cfg_num_act(cfg_num_act),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_row(w_row), .w_col(w_col),
    .w_ch(w_ch), .w_last(w_last),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_row(a_row), .a_col(a_col),
    .a_mask(a_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_mask(out_mask), .out_ch(out_ch), .group_done(group_done)
  );

  typedef struct {
    logic [3:0][15:0] w;
    logic [3:0][4:0]  wr, wc;
    int               nw;
    logic [3:0][15:0] a;
    logic [3:0][4:0]  ar, ac;
    logic [3:0]       am;
    int               ef, ei;
    logic [31:0]      ed;
    logic [5:0]       er, ec;
    logic [15:0]      em;
  } vec_t;

  vec_t tv[5];
  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;
  logic [31:0] mon_q[$];

  always @(negedge clk)
    if (mon_en && out_valid && out_ready) mon_q.push_back(out_data[31:0]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] get_d(input int f, input int i);
    return out_data[(f*I+i)*32 +: 32];
  endfunction
  function automatic logic [5:0] get_r(input int f, input int i);
    return out_row[(f*I+i)*6 +: 6];
  endfunction
  function automatic logic [5:0] get_c(input int f, input int i);
    return out_col[(f*I+i)*6 +: 6];
  endfunction

  task automatic load_w(input logic [3:0][15:0] w, input logic [3:0][4:0] wr, input logic [3:0][4:0] wc,
                        input int nw, input logic [15:0] cfg, input logic [5:0] ch);
    int n;
    cfg_num_act = cfg;
    w_ch = ch;
    for (int b = 0; b < nw; b++) begin
      w_valid = 1'b1;
      w_data = w[b];
      w_row = wr[b];
      w_col = wc[b];
      w_last = (b == nw - 1);
      #1;
      n = 0;
      while (!w_ready && n < 20) begin tick(); n++; end
      if (n >= 20) chk("w_ready_timeout", 64'(w_ready), 64'd1);
      tick();
    end
    w_valid = 1'b0;
    w_last = 1'b0;
  endtask

  task automatic send(input logic [3:0][15:0] a, input logic [3:0][4:0] ar, input logic [3:0][4:0] ac,
                      input logic [3:0] am);
    int n;
    a_data = a;
    a_row = ar;
    a_col = ac;
    a_mask = am;
    a_valid = 1'b1;
    #1;
    n = 0;
    while (!a_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("a_ready_timeout", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
  endtask

  task automatic wait_gd(input string name);
    int n = 0;
    while (!group_done && n < 20) begin tick(); n++; end
    chk(name, 64'(group_done), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input logic [5:0] ch);
    load_w(v.w, v.wr, v.wc, v.nw, 16'd1, ch);
    send(v.a, v.ar, v.ac, v.am);
    chk("tv_out_valid", 64'(out_valid), 64'd1);
    chk("tv_data", 64'(get_d(v.ef, v.ei)), 64'(v.ed));
    chk("tv_row", 64'(get_r(v.ef, v.ei)), 64'(v.er));
    chk("tv_col", 64'(get_c(v.ef, v.ei)), 64'(v.ec));
    chk("tv_mask", 64'(out_mask), 64'(v.em));
    chk("tv_ch", 64'(out_ch), 64'(ch));
    tick();
    chk("tv_group_done", 64'(group_done), 64'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Main pattern, short group, extremes, signed mix, last-row/no-wrap.
    tv[0] = '{w:{16'd4, 16'd3, 16'hFFFE, 16'd1}, wr:{5'd1, 5'd1, 5'd0, 5'd0}, wc:{5'd1, 5'd0, 5'd1, 5'd0}, nw:4,
              a:{16'd40, 16'd30, 16'd20, 16'd10}, ar:{4{5'd2}}, ac:{4{5'd2}}, am:4'b1111,
              ef:1, ei:2, ed:32'hFFFFFFC4, er:6'd2, ec:6'd3, em:16'hFFFF};
    tv[1] = '{w:{16'd4, 16'd3, 16'hFFFE, 16'd1}, wr:{5'd1, 5'd1, 5'd0, 5'd0}, wc:{5'd1, 5'd0, 5'd1, 5'd0}, nw:2,
              a:{16'd40, 16'd30, 16'd20, 16'd10}, ar:{4{5'd2}}, ac:{4{5'd2}}, am:4'b0101,
              ef:1, ei:0, ed:32'hFFFFFFEC, er:6'd2, ec:6'd3, em:16'h0055};
    tv[2] = '{w:{16'd0, 16'd0, 16'd0, 16'h8000}, wr:{5'd0, 5'd0, 5'd0, 5'd31}, wc:{5'd0, 5'd0, 5'd0, 5'd31}, nw:1,
              a:{16'd0, 16'd0, 16'd0, 16'h8000}, ar:{5'd0, 5'd0, 5'd0, 5'd31}, ac:{5'd0, 5'd0, 5'd0, 5'd31}, am:4'b0001,
              ef:0, ei:0, ed:32'h40000000, er:6'd62, ec:6'd62, em:16'h0001};
    tv[3] = '{w:{16'd0, 16'd0, 16'd0, 16'hFFFF}, wr:{5'd0, 5'd0, 5'd0, 5'd4}, wc:{5'd0, 5'd0, 5'd0, 5'd5}, nw:1,
              a:{16'd0, 16'd0, 16'd32767, 16'd0}, ar:{5'd0, 5'd0, 5'd3, 5'd0}, ac:{5'd0, 5'd0, 5'd0, 5'd0}, am:4'b1111,
              ef:0, ei:1, ed:32'hFFFF8001, er:6'd7, ec:6'd5, em:16'h000F};
    tv[4] = '{w:{16'd100, 16'd7, 16'd7, 16'd7}, wr:{5'd10, 5'd0, 5'd0, 5'd0}, wc:{5'd31, 5'd0, 5'd0, 5'd0}, nw:4,
              a:{16'hFFFD, 16'd1, 16'd1, 16'd1}, ar:{5'd20, 5'd0, 5'd0, 5'd0}, ac:{5'd1, 5'd0, 5'd0, 5'd0}, am:4'b1000,
              ef:3, ei:3, ed:32'hFFFFFED4, er:6'd30, ec:6'd32, em:16'h8888};

    irst_n = 1'b0; cfg_num_act = '0; w_valid = 0; w_data = '0; w_row = '0; w_col = '0; w_ch = '0; w_last = 0;
    a_valid = 0; a_data = '0; a_row = '0; a_col = '0; a_mask = '0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_w_ready", 64'(w_ready), 64'd1);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data_zero", 64'(out_data == '0), 64'd1);
    chk("rst_group_done", 64'(group_done), 64'd0);
    irst_n = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) run_vec(tv[k], 6'(k + 1));

    // Two-vector group: pulse lands one cycle after the second output is presented.
    load_w(tv[0].w, tv[0].wr, tv[0].wc, 4, 16'd2, 6'd5);
    send(tv[0].a, tv[0].ar, tv[0].ac, tv[0].am);
    chk("main_v1_valid", 64'(out_valid), 64'd1);
    chk("main_v1_d12", 64'(get_d(1, 2)), 64'hFFFFFFC4);
    chk("main_gd_early", 64'(group_done), 64'd0);
    send(tv[0].a, tv[0].ar, tv[0].ac, tv[0].am);
    chk("main_v2_valid", 64'(out_valid), 64'd1);
    chk("main_v2_d33", 64'(get_d(3, 3)), 64'd160);
    chk("main_ch", 64'(out_ch), 64'd5);
    tick();
    chk("main_gd", 64'(group_done), 64'd1);
    tick();
    chk("main_gd_pulse", 64'(group_done), 64'd0);
    chk("main_out_empty", 64'(out_valid), 64'd0);

    // Backpressure: held output, three vectors in, exactly three out in order.
    mon_q.delete();
    mon_en = 1'b1;
    out_ready = 1'b0;
    load_w({16'd0, 16'd0, 16'd0, 16'd5}, '0, '0, 1, 16'd3, 6'd9);
    send({16'd0, 16'd0, 16'd0, 16'd1}, '0, '0, 4'b0001);
    a_data = {16'd0, 16'd0, 16'd0, 16'd2};
    a_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_a_ready_low", 64'(a_ready), 64'd0);
      chk("bp_data_stable", 64'(get_d(0, 0)), 64'd5);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_a_ready_release", 64'(a_ready), 64'd1);
    tick();
    a_data = {16'd0, 16'd0, 16'd0, 16'd3};
    tick();
    a_valid = 1'b0;
    wait_gd("bp_group_done");
    tick();
    mon_en = 1'b0;
    chk("bp_count", 64'(mon_q.size()), 64'd3);
    if (mon_q.size() == 3) begin
      chk("bp_out0", 64'(mon_q[0]), 64'd5);
      chk("bp_out1", 64'(mon_q[1]), 64'd10);
      chk("bp_out2", 64'(mon_q[2]), 64'd15);
    end

    // Zero-length group.
    load_w({16'd0, 16'd0, 16'd0, 16'd3}, '0, '0, 1, 16'd0, 6'd2);
    chk("z_a_ready", 64'(a_ready), 64'd0);
    tick();
    chk("z_gd_not_yet", 64'(group_done), 64'd0);
    chk("z_no_valid", 64'(out_valid), 64'd0);
    tick();
    chk("z_gd", 64'(group_done), 64'd1);
    chk("z_w_ready", 64'(w_ready), 64'd1);
    chk("z_no_valid2", 64'(out_valid), 64'd0);

    // Reset in the middle of a stream abandons the group silently.
    tick();
    load_w(tv[0].w, tv[0].wr, tv[0].wc, 2, 16'd3, 6'd7);
    send(tv[0].a, tv[0].ar, tv[0].ac, tv[0].am);
    chk("mr_valid_before", 64'(out_valid), 64'd1);
    irst_n = 1'b0;
    tick();
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_out_data", 64'(out_data == '0), 64'd1);
    chk("mr_out_mask", 64'(out_mask), 64'd0);
    chk("mr_out_ch", 64'(out_ch), 64'd0);
    chk("mr_w_ready", 64'(w_ready), 64'd1);
    chk("mr_a_ready", 64'(a_ready), 64'd0);
    irst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("mr_no_gd", 64'(group_done), 64'd0);
      tick();
    end
    run_vec(tv[0], 6'd11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
